lcd_cmd_sched: RTL and testbench

Command scheduler placed in front of the LCD image controller. It buffers a stream of 4-bit host commands in a FIFO and issues them one at a time on the controller's cmd/cmd_valid interface, pacing issue by the controller's busy and done. It drops illegal opcodes and reports sequence completion once the write-out (cmd 0) finishes.

---
 rtl/lcd_cmd_sched.sv | 146 ++++++++++++++
 tb/tb_lcd_cmd_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sched.sv
// Command scheduler in front of the LCD image controller: buffers host opcodes in a FIFO
// and issues them one at a time, paced by lcd_busy/lcd_done. Optional watchdog: LCD_SCHED_WDOG_EN.
module lcd_cmd_sched #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               lcd_cmd,
    output logic                     lcd_cmd_valid,
    input  logic                     lcd_busy,
    input  logic                     lcd_done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               illegal_cnt,
    output logic [7:0]               issued_cnt,
    output logic                     seq_done,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    state_t        state, next_state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, store, pop, flush, wdog_hit;

    // Ready depends on registered state only, so a full FIFO refuses a push even on a pop cycle.
    assign host_ready    = (state != S_INIT) && (state != S_DONE) && (fifo_level < FULL_LVL);
    assign push          = host_valid && host_ready;
    assign store         = push && (host_cmd < 4'd12);
    assign lcd_cmd_valid = (state == S_ISSUE);
    assign seq_done      = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= next_state;
    end

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state)
            S_INIT:  if (!lcd_busy) next_state = S_IDLE;
            S_IDLE: begin
                if ((fifo_level != '0) && !lcd_busy) begin
                    pop        = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: next_state = S_GUARD;
            S_GUARD: begin
                if (lcd_cmd == 4'd0) begin
                    flush      = 1'b1;
                    next_state = S_DRAIN;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT:  if (!lcd_busy || wdog_hit) next_state = S_IDLE;
            S_DRAIN: if (lcd_done || wdog_hit) next_state = S_DONE;
            S_DONE:  next_state = S_DONE;
            default: next_state = S_INIT;
        endcase
    end

    // NOTE: the storage array is not reset; fifo_level alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= host_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            lcd_cmd    <= 4'd0;
        end else begin
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (store) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
                case ({store, pop})
                    2'b10:   fifo_level <= fifo_level + 1'b1;
                    2'b01:   fifo_level <= fifo_level - 1'b1;
                    default: fifo_level <= fifo_level;
                endcase
            end
            if (pop) lcd_cmd <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_cnt <= 8'd0;
            issued_cnt  <= 8'd0;
        end else begin
            if (push && !store && (illegal_cnt != 8'hFF)) illegal_cnt <= illegal_cnt + 8'd1;
            if (state == S_ISSUE) issued_cnt <= issued_cnt + 8'd1;
        end
    end

`ifdef LCD_SCHED_WDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wdog_cnt;
    logic          wdog_err;

    // Fires on the TIMEOUT_CYC-th consecutive cycle spent in WAIT or DRAIN.
    assign wdog_hit = ((state == S_WAIT) || (state == S_DRAIN)) &&
                      (wdog_cnt == CW'(TIMEOUT_CYC - 1));
    assign err      = wdog_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (next_state != state)
                wdog_cnt <= '0;
            else if ((state == S_WAIT) || (state == S_DRAIN))
                wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_hit && (((state == S_WAIT) && lcd_busy) || ((state == S_DRAIN) && !lcd_done)))
                wdog_err <= 1'b1;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYC;

    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: directed steps plus random opcode streams,
// checked against an order/count model of what must reach the LCD controller.
module tb_lcd_cmd_sched;

    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic                     clk;
    logic                     reset;
    logic [3:0]               host_cmd;
    logic                     host_valid;
    logic                     host_ready;
    logic [3:0]               lcd_cmd;
    logic                     lcd_cmd_valid;
    logic                     lcd_busy;
    logic                     lcd_done;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [7:0]               illegal_cnt;
    logic [7:0]               issued_cnt;
    logic                     seq_done;
    logic                     err;

    lcd_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .lcd_cmd      (lcd_cmd),
        .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy     (lcd_busy),
        .lcd_done     (lcd_done),
        .fifo_level   (fifo_level),
        .illegal_cnt  (illegal_cnt),
        .issued_cnt   (issued_cnt),
        .seq_done     (seq_done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: opcodes the controller must see, in order, plus expected counters.
    logic [3:0] exp_q[$];
    int         exp_issued  = 0;
    int         exp_illegal = 0;
    bit         closed      = 1'b0;
    bit         spacing_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [3:0] c);
        if (c >= 4'd12) begin
            if (exp_illegal < 255) exp_illegal++;
        end else if (!closed) begin
            exp_q.push_back(c);
            exp_issued++;
            if (c == 4'd0) closed = 1'b1;
        end
    endtask

    task automatic push(input logic [3:0] c);
        int n = 0;
        host_cmd   = c;
        host_valid = 1'b1;
        while (!host_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_accept", host_ready, 1);
        if (host_ready) begin
            tick();
            model_accept(c);
        end
        host_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        tick();
        while (!lcd_cmd_valid && n < 60) begin
            tick();
            n++;
        end
        check(tag, lcd_cmd_valid, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {host_ready, lcd_cmd, lcd_cmd_valid, fifo_level, illegal_cnt,
                    issued_cnt, seq_done, err}, 0);
    endtask

    task automatic start_run(input int busy_cycles);
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 4'd0;
        lcd_busy   = 1'b1;
        lcd_done   = 1'b0;
        exp_q.delete();
        exp_issued  = 0;
        exp_illegal = 0;
        closed      = 1'b0;
        tick();
        tick();
        check_all_zero("reset_values");
        reset = 1'b0;
        for (int i = 0; i < busy_cycles; i++) begin
            tick();
            check("ready_during_load", host_ready, 0);
        end
        lcd_busy = 1'b0;
        tick();
        check("ready_after_load", host_ready, 1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_queue"}, exp_q.size(), 0);
        check({tag, "_issued"}, issued_cnt, exp_issued % 256);
        check({tag, "_illegal"}, illegal_cnt, exp_illegal);
    endtask

    // Issue monitor: order, one-cycle pulse spacing and hold-when-idle of lcd_cmd.
    int         cyc      = 0;
    int         last_cyc = -1;
    logic [3:0] last_cmd = 4'd0;

    always @(negedge clk) begin
        cyc++;
        if (!spacing_chk) last_cyc = -1;
        if (reset) begin
            last_cmd = 4'd0;
        end else if (lcd_cmd_valid) begin
            if (exp_q.size() == 0) begin
                check("issue_unexpected", lcd_cmd, 16);
            end else begin
                check("issue_order", lcd_cmd, exp_q.pop_front());
            end
            if (spacing_chk && last_cyc >= 0) check("issue_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            last_cmd = lcd_cmd;
        end else begin
            check("cmd_hold", lcd_cmd, last_cmd);
        end
    end

    initial begin
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 4'd0;
        lcd_busy   = 1'b1;
        lcd_done   = 1'b0;

        // Run 1: 64-cycle image load, then normal traffic.
        start_run(64);

        spacing_chk = 1'b1;
        push(4'd3);
        push(4'd1);
        push(4'd7);
        repeat (16) tick();
        spacing_chk = 1'b0;
        check("three_issued", issued_cnt, 3);
        check_drained("seq317");

        push(4'd13);
        push(4'd15);
        push(4'd5);
        repeat (10) tick();
        check("illegal_two", illegal_cnt, 2);
        check_drained("illegal");

        for (int i = 0; i < 24; i++) begin
            lcd_busy = 1'b1;
            repeat ($urandom_range(0, 3)) tick();
            lcd_busy = 1'b0;
            push(4'($urandom_range(1, 15)));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (60) tick();
        check_drained("random");

        // Fill while the controller is busy; a 9th push waits for the first pop.
        lcd_busy = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) push(4'($urandom_range(1, 11)));
        check("fill_level", fifo_level, DEPTH);
        check("fill_ready", host_ready, 0);
        host_cmd   = 4'd10;
        host_valid = 1'b1;
        repeat (3) begin
            tick();
            check("held_ready", host_ready, 0);
            check("held_level", fifo_level, DEPTH);
        end
        lcd_busy = 1'b0;
        push(4'd10);
        check("refill_level", fifo_level, DEPTH);
        repeat (50) tick();
        check_drained("fill");

        // Write-out: 9 and 0 issue, 4 is flushed on DRAIN entry.
        push(4'd9);
        push(4'd0);
        push(4'd4);
        begin
            int n = 0;
            while (!(lcd_cmd_valid && lcd_cmd == 4'd0) && n < 40) begin
                tick();
                n++;
            end
            check("wr_issued", {lcd_cmd_valid, lcd_cmd}, 5'h10);
        end
        repeat (10) tick();
        check("drain_seq_done", seq_done, 0);
        check("drain_flushed", fifo_level, 0);
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        check("done_seq_done", seq_done, 1);
        check("done_ready", host_ready, 0);
        host_cmd   = 4'd5;
        host_valid = 1'b1;
        repeat (10) tick();
        host_valid = 1'b0;
        check("done_sticky", {seq_done, host_ready}, 2'b10);
        check_drained("writeout");

        // Run 2: watchdog behaviour, then reset in the middle of DRAIN.
        start_run(5);
        push(4'd2);
        wait_valid("wdog_issue");
        lcd_busy = 1'b1;
`ifdef LCD_SCHED_WDOG_EN
        repeat (21) tick();
        check("wdog_before", err, 0);
        tick();
        check("wdog_fired", err, 1);
        push(4'd6);
        lcd_busy = 1'b0;
        tick();
        check("wdog_back_idle", {lcd_cmd_valid, lcd_cmd}, 5'h16);
        repeat (10) tick();
        check("wdog_sticky", err, 1);
`else
        repeat (40) tick();
        check("no_wdog", err, 0);
        lcd_busy = 1'b0;
        repeat (10) tick();
        check("no_wdog_after", err, 0);
`endif
        check_drained("wdog");

        push(4'd0);
        wait_valid("run2_wr_issue");
        repeat (4) tick();
        check("run2_in_drain", {seq_done, host_ready}, 2'b01);
        reset = 1'b1;
        #1;
        check_all_zero("mid_drain_reset");
        exp_q.delete();
        tick();
        tick();
        check_all_zero("mid_drain_hold");
        reset       = 1'b0;
        exp_issued  = 0;
        exp_illegal = 0;
        closed      = 1'b0;
        lcd_busy    = 1'b0;
        tick();
        check("post_reset_ready", host_ready, 1);
        push(4'd11);
        repeat (10) tick();
        check_drained("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
